ifu_jalr_tgt_ctrl: RTL

//  Sequences JALR target-operand fetch for the IFU lite branch predictor. Tracks outstanding

---
 rtl/ifu_jalr_tgt_ctrl_pkg.sv | 19 +
 rtl/ifu_jalr_tgt_ctrl_sb_cnt.sv | 46 ++++
 rtl/ifu_jalr_tgt_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ifu_jalr_tgt_ctrl_pkg.sv
// Shared types and default sizes for the JALR target-operand controller.
//  jtc_state_e : FSM state encoding (2 bits)
//  Jtc*        : default widths used as parameter defaults by the top
package ifu_jalr_tgt_ctrl_pkg;

  localparam int unsigned JtcPcSize     = 32;
  localparam int unsigned JtcXlen       = 32;
  localparam int unsigned JtcRfidxWidth = 5;
  localparam int unsigned JtcCntW       = 3;
  localparam int unsigned JtcStarveMax  = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDepWait = 2'd1,
    StRfReq   = 2'd2,
    StRfData  = 2'd3
  } jtc_state_e;

endpackage

// File: rtl/ifu_jalr_tgt_ctrl_sb_cnt.sv
// Scoreboard counter: tracks outstanding register writes.
// Ports:
//  clk, rst  clock / async active-low reset
//  inc, dec  one write dispatched / one write retired (both -> unchanged)
//  full      counter at 2**CNT_W-1, dispatch must stall writers
//  empty     counter at zero, no outstanding writes
module ifu_jalr_tgt_ctrl_sb_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full  = (cnt_q == CntMax);
  assign empty = (cnt_q == '0);

  // Wrapping would silently lose a hazard; upstream stalls must prevent it.
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(inc && !dec && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(dec && !inc && empty));

endmodule

// File: rtl/ifu_jalr_tgt_ctrl.sv
// JALR target-operand sequencer for the IFU lite branch predictor.
// Waits out write hazards on rs1 (x1 counter / any-GPR counter), arbitrates regfile read
// port 1 against dispatch with starvation protection, and delivers rs1 as the adder op1.
// Ports:
//  clk, rst                      clock / async active-low reset
//  jalr_req, jalr_rs1idx         JALR in IR and its rs1 index (held until resolve or flush)
//  disp_wen, disp_x1_wen         dispatched instruction writes a GPR / x1
//  wb_wen, wb_x1_wen             writeback retires a GPR / x1 write
//  disp_rs1_ren                  dispatch wants read port 1
//  flush                         pipeline flush, abandons the current JALR
//  rf2bpu_x1, rf2bpu_rs1         dedicated x1 read / port 1 data (cycle after grant)
//  bpu2rf_rs1_ena, disp_rs1_gnt  read port 1 owner this cycle
//  sb_full                       either scoreboard counter saturated
//  bpu_wait                      JALR pending and not resolved, freeze PC
//  tgt_resolve, tgt_op1          op1 valid pulse and value
module ifu_jalr_tgt_ctrl
  import ifu_jalr_tgt_ctrl_pkg::*;
#(
  parameter int unsigned PC_SIZE     = JtcPcSize,
  parameter int unsigned XLEN        = JtcXlen,
  parameter int unsigned RFIDX_WIDTH = JtcRfidxWidth,
  parameter int unsigned CNT_W       = JtcCntW,
  parameter int unsigned STARVE_MAX  = JtcStarveMax
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jalr_req,
  input  logic [RFIDX_WIDTH-1:0] jalr_rs1idx,
  input  logic                   disp_wen,
  input  logic                   disp_x1_wen,
  input  logic                   wb_wen,
  input  logic                   wb_x1_wen,
  input  logic                   disp_rs1_ren,
  input  logic                   flush,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  output logic                   bpu2rf_rs1_ena,
  output logic                   disp_rs1_gnt,
  output logic                   sb_full,
  output logic                   bpu_wait,
  output logic                   tgt_resolve,
  output logic [PC_SIZE-1:0]     tgt_op1
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  jtc_state_e         state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [PC_SIZE-1:0] op1_q;

  logic any_full, any_empty, x1_full, x1_empty;
  logic is_x0, is_x1;
  logic resolve_c, bpu_gnt_c, disp_gnt_c;
  logic [PC_SIZE-1:0] op1_c;

  ifu_jalr_tgt_ctrl_sb_cnt #(
    .CNT_W (CNT_W)
  ) u_any_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (disp_wen),
    .dec   (wb_wen),
    .full  (any_full),
    .empty (any_empty)
  );

  ifu_jalr_tgt_ctrl_sb_cnt #(
    .CNT_W (CNT_W)
  ) u_x1_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (disp_x1_wen),
    .dec   (wb_x1_wen),
    .full  (x1_full),
    .empty (x1_empty)
  );

  assign is_x0 = (jalr_rs1idx == '0);
  assign is_x1 = (jalr_rs1idx == RFIDX_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    resolve_c  = 1'b0;
    op1_c      = '0;
    bpu_gnt_c  = 1'b0;
    disp_gnt_c = disp_rs1_ren;

    unique case (state_q)
      StIdle: begin
        if (jalr_req) begin
          if (is_x0) begin
            resolve_c = 1'b1;
          end else if (is_x1) begin
            if (x1_empty) begin
              resolve_c = 1'b1;
              op1_c     = rf2bpu_x1[PC_SIZE-1:0];
            end else begin
              state_d = StDepWait;
            end
          end else if (any_empty) begin
            state_d = StRfReq;
          end else begin
            state_d = StDepWait;
          end
        end
      end
      StDepWait: begin
        // x1 goes back through IDLE, which reads the dedicated x1 port.
        if (is_x1 && x1_empty) begin
          state_d = StIdle;
        end else if (!is_x1 && any_empty) begin
          state_d = StRfReq;
        end
      end
      StRfReq: begin
        if (!disp_rs1_ren || (starve_q == SW'(STARVE_MAX))) begin
          bpu_gnt_c  = 1'b1;
          disp_gnt_c = 1'b0;
          starve_d   = '0;
          state_d    = StRfData;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      StRfData: begin
        resolve_c = 1'b1;
        op1_c     = rf2bpu_rs1[PC_SIZE-1:0];
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A grant already given this cycle stays; only the result is dropped.
    if (flush) begin
      state_d   = StIdle;
      starve_d  = '0;
      resolve_c = 1'b0;
      op1_c     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      starve_q <= '0;
      op1_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (state_q == StRfData && !flush) begin
        op1_q <= rf2bpu_rs1[PC_SIZE-1:0];
      end
    end
  end

  // Outputs are forced low while reset is asserted so no pulse escapes mid-operation.
  assign tgt_resolve    = rst & resolve_c;
  assign tgt_op1        = rst ? op1_c : '0;
  assign bpu2rf_rs1_ena = rst & bpu_gnt_c;
  assign disp_rs1_gnt   = rst & disp_gnt_c;
  assign bpu_wait       = rst & jalr_req & ~resolve_c;
  assign sb_full        = rst & (any_full | x1_full);

  a_req_held: assert property (@(posedge clk) disable iff (!rst)
    (jalr_req && !tgt_resolve && !flush) |=> jalr_req);
  a_one_owner: assert property (@(posedge clk) disable iff (!rst)
    !(bpu2rf_rs1_ena && disp_rs1_gnt));
  a_disp_x1: assert property (@(posedge clk) disable iff (!rst) disp_x1_wen |-> disp_wen);
  a_wb_x1: assert property (@(posedge clk) disable iff (!rst) wb_x1_wen |-> wb_wen);
  a_op1_cap: assert property (@(posedge clk) disable iff (!rst)
    (state_q == StRfData && !flush) |=> (op1_q == $past(rf2bpu_rs1[PC_SIZE-1:0])));

endmodule
